dcache_store_buffer: RTL
========================

DCACHE_STORE_BUFFER -- requirements
Module: dcache_store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered store entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have up_request, up_rnw, up_is_amo  input  1 each  upstream request from the dcache L1 request side.
REQ-005 SHALL have up_addr[31:0], up_data[31:0], up_be[3:0], up_size[4:0], up_amo[4:0]  input  upstream request fields.
REQ-006 SHALL have up_ack  output  1  upstream request accepted this cycle.
REQ-007 SHALL have dn_request, dn_rnw, dn_is_amo  output  1 each  request toward the L1 arbiter.
REQ-008 SHALL have dn_addr[31:0], dn_data[31:0], dn_be[3:0], dn_size[4:0], dn_amo[4:0]  output  downstream request fields.
REQ-009 SHALL have dn_ack  input  1  downstream request accepted this cycle.
REQ-010 SHALL have empty  output  1 (buffer holds no store) and count  output  $clog2(DEPTH+1)  number of occupied entries.

Function
REQ-011 An upstream request with up_rnw=0 and up_is_amo=0 is a "plain store"; every other request is "non-store" (load, LR, SC, AMO).
REQ-012 Plain store: up_ack = up_request when count<DEPTH, combinationally in the same cycle; entry written at the tail on that edge.
REQ-013 Plain store with count==DEPTH: up_ack=0, even if dn_ack pops in the same cycle; the store is accepted on a later cycle.
REQ-014 Non-store with empty=1: pass-through; all dn_* fields equal the up_* fields combinationally, dn_request=up_request, up_ack=dn_ack.
REQ-015 Non-store with empty=0: up_ack=0 and the request is not forwarded until the buffer drains (ordering: no load overtakes an older store).
REQ-016 Buffer non-empty: dn_request=1, dn_* = head entry, dn_rnw=0, dn_size=0, dn_is_amo=0, dn_amo=0.
REQ-017 dn_ack while the buffer is non-empty pops the head on that edge; head pointer increments modulo DEPTH.
REQ-018 Store-to-downstream latency = 1 cycle minimum: a store accepted at edge N appears on dn at the earliest in cycle N+1, never in the acceptance cycle.
REQ-019 Push and pop in the same cycle: count is unchanged; both pointers advance.
REQ-020 Head and tail pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are derived from count only.
REQ-021 Upstream fields are sampled only on a push edge; dn_* outputs are stable while dn_request=1 and dn_ack=0.
REQ-022 dn_* with dn_request=0 SHALL be driven to zero.

Reset
REQ-023 rst_n low asynchronously clears count to 0 and head/tail to 0, drops all entries, and sets empty=1.
REQ-024 While rst_n is low, up_ack=0 and dn_request=0 regardless of other inputs; entry storage need not be cleared.
REQ-025 A store in flight on dn at reset assertion is abandoned; there is no replay after reset release.

Configuration
REQ-026 Macro DCACHE_STORE_BUFFER_COALESCE_EN: when defined, a plain store SHALL merge into the tail entry if count>=2 and up_addr[31:2] equals the tail entry's addr[31:2].
REQ-027 Merge behaviour: up_ack=1 even when count==DEPTH; bytes with up_be set overwrite tail data; tail be |= up_be; count unchanged.
REQ-028 Without the macro, no merging occurs, and stores to the same word occupy separate entries.
REQ-029 The head entry (count==1, or the entry being presented) is never a merge target.

Verification
REQ-030 Empty buffer, store addr=0x100 data=0xDEADBEEF be=0xF with dn_ack tied high -> up_ack=1 in cycle 0; dn_request=1 with matching fields in cycle 1; empty=1 in cycle 2.
REQ-031 dn_ack=0, five stores with DEPTH=4 -> four up_ack pulses, count=4, fifth store up_ack=0; raise dn_ack for one cycle -> fifth store accepted one cycle later.
REQ-032 Two buffered stores, then a load at 0x200 -> up_ack=0 until count=0; the load passes through with dn_rnw=1 and dn_size=up_size.
REQ-033 With COALESCE_EN, count=2, tail addr=0x104 be=0x1 data=0x11; store 0x106 be=0x4 data=0x00220000 -> count=2, tail be=0x5, data=0x00220011.
REQ-034 Three stores queued, assert rst_n=0 mid-cycle -> dn_request=0 and count=0 immediately; after release, new store 0x300 is the only one emitted.
REQ-035 Ring wrap: 10 stores with alternating dn_ack -> dn order matches issue order exactly, and pointers wrap twice without loss.

Source files
------------

// File: rtl/dcache_store_buffer.sv
// ============================================================================
// Module   : dcache_store_buffer
// Purpose  : In-order posted-store buffer between the dcache request side and
//            the L1 arbiter; non-store requests wait for the buffer to drain.
//            Optional macro DCACHE_STORE_BUFFER_COALESCE_EN merges same-word
//            stores into the tail entry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       up_request,
    input  logic                       up_rnw,
    input  logic                       up_is_amo,
    input  logic [31:0]                up_addr,
    input  logic [31:0]                up_data,
    input  logic [3:0]                 up_be,
    input  logic [4:0]                 up_size,
    input  logic [4:0]                 up_amo,
    output logic                       up_ack,
    output logic                       dn_request,
    output logic                       dn_rnw,
    output logic                       dn_is_amo,
    output logic [31:0]                dn_addr,
    output logic [31:0]                dn_data,
    output logic [3:0]                 dn_be,
    output logic [4:0]                 dn_size,
    output logic [4:0]                 dn_amo,
    input  logic                       dn_ack,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [31:0]   r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [3:0]    r_be   [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic w_is_store;
    logic w_empty;
    logic w_full;
    logic w_merge;
    logic w_push;
    logic w_pop;

    assign w_is_store = ~up_rnw & ~up_is_amo;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == C_FULL);

`ifdef DCACHE_STORE_BUFFER_COALESCE_EN
    logic [PW-1:0] w_tail_last;
    assign w_tail_last = r_tail - 1'b1;
    // count>=2 keeps the presented head entry out of the merge path
    assign w_merge = rst_n & up_request & w_is_store & (r_count >= CW'(2)) &
                     (up_addr[31:2] == r_addr[w_tail_last][31:2]);
`else
    assign w_merge = 1'b0;
`endif

    assign w_push = rst_n & up_request & w_is_store & ~w_full & ~w_merge;
    assign w_pop  = rst_n & ~w_empty & dn_ack;

    assign up_ack = w_push | w_merge |
                    (rst_n & up_request & ~w_is_store & w_empty & dn_ack);

    assign empty = w_empty;
    assign count = r_count;

    // Entry storage is not reset; occupancy is tracked solely by r_count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= up_addr;
            r_data[r_tail] <= up_data;
            r_be[r_tail]   <= up_be;
        end
`ifdef DCACHE_STORE_BUFFER_COALESCE_EN
        else if (w_merge) begin
            for (int b = 0; b < 4; b++) begin
                if (up_be[b]) begin
                    r_data[w_tail_last][8*b +: 8] <= up_data[8*b +: 8];
                end
            end
            r_be[w_tail_last] <= r_be[w_tail_last] | up_be;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Buffered stores take priority; a non-store only reaches dn once drained
    always_comb begin
        dn_request = 1'b0;
        dn_rnw     = 1'b0;
        dn_is_amo  = 1'b0;
        dn_addr    = '0;
        dn_data    = '0;
        dn_be      = '0;
        dn_size    = '0;
        dn_amo     = '0;
        if (rst_n) begin
            if (!w_empty) begin
                dn_request = 1'b1;
                dn_addr    = r_addr[r_head];
                dn_data    = r_data[r_head];
                dn_be      = r_be[r_head];
            end else if (up_request && !w_is_store) begin
                dn_request = 1'b1;
                dn_rnw     = up_rnw;
                dn_is_amo  = up_is_amo;
                dn_addr    = up_addr;
                dn_data    = up_data;
                dn_be      = up_be;
                dn_size    = up_size;
                dn_amo     = up_amo;
            end
        end
    end

endmodule

`default_nettype wire
